shared_ram_apb_ahb: RTL and testbench

//  One synchronous RAM shared by an APB slave port and an AHB-Lite slave port on a common clock.
//  A two-way round-robin arbiter grants at most one memory access per cycle.

---
 rtl/ram_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/shared_ram_apb_ahb.sv | 207 ++++++++++++++++++++
 tb/tb_shared_ram_apb_ahb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the APB/AHB shared-RAM block.
package ram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      ERR1,
      ERR2
   } port_state_t;

   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // byte-lane mask for a naturally aligned AHB transfer, up to 8 lanes
   function automatic logic [7:0] ahb_lane_mask(
      input logic [2:0] size,
      input logic [2:0] lsbs
   );
      logic [7:0] base;
      logic [2:0] al;
      unique case (size)
         3'd0:    base = 8'h01;
         3'd1:    base = 8'h03;
         3'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      al = lsbs & ~(3'((4'd1 << size) - 4'd1));
      return base << al;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; port 0 = APB, port 1 = AHB.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
         default:        gnt = req;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (|gnt)
         last <= gnt[1];
   end

endmodule

// File: rtl/shared_ram_apb_ahb.sv
// Single-port RAM shared by an APB slave and an AHB-Lite slave,
// one round-robin arbitrated access per cycle, WAITS wait states each.
module shared_ram_apb_ahb
   import ram_pkg::*;
#(
   parameter int AWIDTH   = 10,
   parameter int DSIZE    = 2,
   parameter int MEMWORDS = 1 << (AWIDTH - DSIZE),
   parameter int WAITS    = 0,
   localparam int DBYTES  = 1 << DSIZE,
   localparam int DWIDTH  = DBYTES * 8
) (
   input  logic              xclk,
   input  logic              xreset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [2:0]        pprot,
   input  logic [AWIDTH-1:0] paddr,
   input  logic [DBYTES-1:0] pstrb,
   input  logic [DWIDTH-1:0] pwdata,
   output logic [DWIDTH-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic              hsel,
   input  logic              hready,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [AWIDTH-1:0] haddr,
   input  logic [DWIDTH-1:0] hwdata,
   input  logic [3:0]        hprot,
   input  logic [2:0]        hburst,
   input  logic              hmastlock,
   output logic [DWIDTH-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int IW  = AWIDTH - DSIZE;
   localparam int MIW = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
   localparam logic [IW:0] MLIM  = (IW + 1)'(MEMWORDS);
   localparam logic [3:0]  WLOAD = (WAITS > 0) ? 4'(WAITS - 1) : 4'd0;

   logic [DWIDTH-1:0] mem [MEMWORDS];

   port_state_t ast, ast_nx, hst, hst_nx;
   logic [3:0] acnt, hcnt;
   logic areq, hreq;
   logic [1:0] gnt;
   logic [DWIDTH-1:0] aq, hq, prdata_r, hrdata_r;
   logic [AWIDTH-1:0] ha_q;
   logic hw_q;
   logic [2:0] hs_q;
   logic [IW-1:0] aidx, hidx;
   logic aerr, herr, hacc, hopen;
   logic [7:0] hm8;
   logic [DBYTES-1:0] hmask;
   logic unused_ok;

   assign aidx  = paddr[AWIDTH-1:DSIZE];
   assign hidx  = ha_q[AWIDTH-1:DSIZE];
   assign aerr  = {1'b0, aidx} >= MLIM;
   assign herr  = ({1'b0, haddr[AWIDTH-1:DSIZE]} >= MLIM) |
                  (hsize > 3'(DSIZE));
   assign hacc  = hsel & hready &
                  ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
   assign hopen = (hst == IDLE) | (hst == DONE) | (hst == ERR2);
   assign hm8   = ahb_lane_mask(hs_q, 3'(ha_q[DSIZE-1:0]));
   assign hmask = hm8[DBYTES-1:0];

   assign unused_ok = ^{pprot, hprot, hburst, hmastlock,
                        paddr[DSIZE-1:0], hm8};

   rr_arb2 u_arb (
      .clk (xclk),
      .rst (xreset),
      .req ({hreq, areq}),
      .gnt (gnt)
   );

   always_comb begin
      ast_nx  = ast;
      areq    = 1'b0;
      pready  = 1'b0;
      pslverr = 1'b0;
      unique case (ast)
         IDLE: begin
            if (psel & penable) begin
               if (aerr) begin
                  ast_nx = ERR1;
               end else begin
                  areq = 1'b1;
                  if (gnt[0])
                     ast_nx = (WAITS == 0) ? DONE : WAIT;
                  else
                     ast_nx = REQ;
               end
            end
         end
         REQ: begin
            areq = 1'b1;
            if (gnt[0])
               ast_nx = (WAITS == 0) ? DONE : WAIT;
         end
         WAIT: if (acnt == 4'd0) ast_nx = DONE;
         DONE: begin
            pready = 1'b1;
            ast_nx = IDLE;
         end
         ERR1: begin
            pready  = 1'b1;
            pslverr = 1'b1;
            ast_nx  = IDLE;
         end
         default: ast_nx = IDLE;
      endcase
   end

   always_comb begin
      hst_nx    = hst;
      hreq      = 1'b0;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      unique case (hst)
         REQ: begin
            hreadyout = 1'b0;
            hreq      = 1'b1;
            if (gnt[1])
               hst_nx = (WAITS == 0) ? DONE : WAIT;
         end
         WAIT: begin
            hreadyout = 1'b0;
            if (hcnt == 4'd0) hst_nx = DONE;
         end
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            hst_nx    = ERR2;
         end
         ERR2: begin
            hresp  = HRESP_ERROR;
            hst_nx = IDLE;
         end
         default: hst_nx = IDLE;
      endcase
      // pipelined address phase overrides the return to IDLE
      if (hopen && hacc)
         hst_nx = herr ? ERR1 : REQ;
   end

   assign prdata = (ast == DONE) ? aq : prdata_r;
   assign hrdata = (hst == DONE) ? hq : hrdata_r;

   always_ff @(posedge xclk or posedge xreset) begin
      if (xreset) begin
         ast      <= IDLE;
         hst      <= IDLE;
         acnt     <= 4'd0;
         hcnt     <= 4'd0;
         aq       <= '0;
         hq       <= '0;
         prdata_r <= '0;
         hrdata_r <= '0;
         ha_q     <= '0;
         hw_q     <= 1'b0;
         hs_q     <= 3'd0;
      end else begin
         ast <= ast_nx;
         hst <= hst_nx;
         if (gnt[0])
            acnt <= WLOAD;
         else if (ast == WAIT)
            acnt <= acnt - 4'd1;
         if (gnt[1])
            hcnt <= WLOAD;
         else if (hst == WAIT)
            hcnt <= hcnt - 4'd1;
         if (gnt[0] && !pwrite)
            aq <= mem[aidx[MIW-1:0]];
         if (gnt[1] && !hw_q)
            hq <= mem[hidx[MIW-1:0]];
         if (ast == DONE)
            prdata_r <= aq;
         if (hst == DONE)
            hrdata_r <= hq;
         if (hopen && hacc) begin
            ha_q <= haddr;
            hw_q <= hwrite;
            hs_q <= hsize;
         end
      end
   end

   // contents survive reset; only the in-flight access is dropped
   always_ff @(posedge xclk) begin
      if (!xreset) begin
         for (int b = 0; b < DBYTES; b++) begin
            if (gnt[0] && pwrite && pstrb[b])
               mem[aidx[MIW-1:0]][b*8 +: 8] <= pwdata[b*8 +: 8];
            if (gnt[1] && hw_q && hmask[b])
               mem[hidx[MIW-1:0]][b*8 +: 8] <= hwdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_shared_ram_apb_ahb.sv
// Directed bench: dut0 has MEMWORDS=128/WAITS=0, dut1 has defaults with WAITS=3.
module tb_shared_ram_apb_ahb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic xreset, sel;
   logic psel, penable, pwrite;
   logic [2:0] pprot;
   logic [9:0] paddr;
   logic [3:0] pstrb;
   logic [31:0] pwdata;
   logic hsel, hwrite, hmastlock;
   logic [1:0] htrans;
   logic [2:0] hsize, hburst;
   logic [3:0] hprot;
   logic [9:0] haddr;
   logic [31:0] hwdata;

   logic [31:0] prdata0, prdata1, hrdata0, hrdata1;
   logic pready0, pready1, pslverr0, pslverr1;
   logic hreadyout0, hreadyout1, hresp0, hresp1;

   logic [31:0] prdata_m, hrdata_m;
   logic pready_m, pslverr_m, hreadyout_m, hresp_m;

   assign prdata_m    = sel ? prdata1 : prdata0;
   assign pready_m    = sel ? pready1 : pready0;
   assign pslverr_m   = sel ? pslverr1 : pslverr0;
   assign hrdata_m    = sel ? hrdata1 : hrdata0;
   assign hreadyout_m = sel ? hreadyout1 : hreadyout0;
   assign hresp_m     = sel ? hresp1 : hresp0;

   int ntests = 0;
   int nfail  = 0;

   logic [9:0]  qa_addr  [8];
   logic        qa_wr    [8];
   logic [2:0]  qa_size  [8];
   logic [31:0] qa_wdata [8];
   logic [31:0] qr_data  [8];
   logic        qr_resp  [8];
   logic        qr_resp1 [8];
   int          qr_low   [8];

   shared_ram_apb_ahb #(.MEMWORDS(128), .WAITS(0)) dut0 (
      .xclk(clk), .xreset(xreset),
      .psel(psel & ~sel), .penable(penable), .pwrite(pwrite),
      .pprot(pprot), .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .hsel(hsel & ~sel), .hready(hreadyout0), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
      .hprot(hprot), .hburst(hburst), .hmastlock(hmastlock),
      .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
   );

   shared_ram_apb_ahb #(.WAITS(3)) dut1 (
      .xclk(clk), .xreset(xreset),
      .psel(psel & sel), .penable(penable), .pwrite(pwrite),
      .pprot(pprot), .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
      .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
      .hsel(hsel & sel), .hready(hreadyout1), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
      .hprot(hprot), .hburst(hburst), .hmastlock(hmastlock),
      .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1)
   );

   task automatic apb_xfer(input logic wr, input logic [9:0] a,
                           input logic [3:0] s, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err,
                           output int n);
      psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = a; pstrb = s; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      while (n < 40) begin
         #1;
         n++;
         if (pready_m) break;
         @(posedge clk); #1;
      end
      rd = prdata_m;
      err = pslverr_m;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic qset(input int k, input logic wr, input logic [9:0] a,
                       input logic [2:0] s, input logic [31:0] d);
      qa_wr[k] = wr; qa_addr[k] = a; qa_size[k] = s; qa_wdata[k] = d;
   endtask

   task automatic ahb_run(input int n);
      int i, d, guard;
      i = 0; d = -1; guard = 0;
      for (int k = 0; k < 8; k++) begin
         qr_low[k] = 0; qr_resp1[k] = 1'b0;
         qr_data[k] = '0; qr_resp[k] = 1'b0;
      end
      while ((i < n || d >= 0) && guard < 200) begin
         if (i < n) begin
            hsel = 1'b1; htrans = 2'b10; haddr = qa_addr[i];
            hwrite = qa_wr[i]; hsize = qa_size[i];
         end else begin
            hsel = 1'b0; htrans = 2'b00;
         end
         hwdata = (d >= 0) ? qa_wdata[d] : 32'h0;
         #1;
         if (hreadyout_m) begin
            if (d >= 0) begin
               qr_data[d] = hrdata_m;
               qr_resp[d] = hresp_m;
            end
            d = (i < n) ? i : -1;
            if (i < n) i++;
         end else if (d >= 0) begin
            qr_low[d]++;
            if (hresp_m) qr_resp1[d] = 1'b1;
         end
         @(posedge clk); #1;
         guard++;
      end
      hsel = 1'b0; htrans = 2'b00;
      if (guard >= 200) begin
         ntests++; nfail++;
         $display("FAIL ahb_timeout: bus never completed");
      end
   endtask

   task automatic test_reset;
      xreset = 1'b1;
      @(posedge clk); #1;
      ntests++; if (prdata0 !== 32'h0) begin nfail++; $display("FAIL rst_prdata got %h want 0", prdata0); end
      ntests++; if (pready0 !== 1'b0) begin nfail++; $display("FAIL rst_pready got %b want 0", pready0); end
      ntests++; if (pslverr0 !== 1'b0) begin nfail++; $display("FAIL rst_pslverr got %b want 0", pslverr0); end
      ntests++; if (hrdata0 !== 32'h0) begin nfail++; $display("FAIL rst_hrdata got %h want 0", hrdata0); end
      ntests++; if (hreadyout0 !== 1'b1) begin nfail++; $display("FAIL rst_hreadyout got %b want 1", hreadyout0); end
      ntests++; if (hresp0 !== 1'b0) begin nfail++; $display("FAIL rst_hresp got %b want 0", hresp0); end
      ntests++; if (hreadyout1 !== 1'b1) begin nfail++; $display("FAIL rst_hreadyout1 got %b want 1", hreadyout1); end
      xreset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_apb_rw;
      logic [31:0] rd;
      logic er;
      int n;
      sel = 1'b0;
      apb_xfer(1'b1, 10'h010, 4'hF, 32'hA5A5_0001, rd, er, n);
      ntests++; if (n !== 2) begin nfail++; $display("FAIL apb_wr_lat got %0d want 2", n); end
      ntests++; if (er !== 1'b0) begin nfail++; $display("FAIL apb_wr_err got %b want 0", er); end
      apb_xfer(1'b0, 10'h010, 4'h0, 32'h0, rd, er, n);
      ntests++; if (n !== 2) begin nfail++; $display("FAIL apb_rd_lat got %0d want 2", n); end
      ntests++; if (rd !== 32'hA5A5_0001) begin nfail++; $display("FAIL apb_rd_data got %h want a5a50001", rd); end
      ntests++; if (er !== 1'b0) begin nfail++; $display("FAIL apb_rd_err got %b want 0", er); end
      apb_xfer(1'b1, 10'h010, 4'b0101, 32'h1122_3344, rd, er, n);
      apb_xfer(1'b0, 10'h010, 4'h0, 32'h0, rd, er, n);
      ntests++; if (rd !== 32'hA522_0044) begin nfail++; $display("FAIL apb_strb got %h want a5220044", rd); end
   endtask

   task automatic test_ahb_lanes;
      sel = 1'b0;
      qset(0, 1'b1, 10'h010, 3'd2, 32'hFFFF_FFFF);
      qset(1, 1'b1, 10'h012, 3'd0, 32'h0077_0000);
      qset(2, 1'b0, 10'h010, 3'd2, 32'h0);
      qset(3, 1'b1, 10'h010, 3'd1, 32'h0000_BEEF);
      qset(4, 1'b0, 10'h010, 3'd2, 32'h0);
      ahb_run(5);
      for (int k = 0; k < 5; k++) begin
         ntests++; if (qr_low[k] !== 1) begin nfail++; $display("FAIL ahb_low[%0d] got %0d want 1", k, qr_low[k]); end
      end
      ntests++; if (qr_data[2] !== 32'hFF77_FFFF) begin nfail++; $display("FAIL ahb_byte got %h want ff77ffff", qr_data[2]); end
      ntests++; if (qr_data[4] !== 32'hFF77_BEEF) begin nfail++; $display("FAIL ahb_half got %h want ff77beef", qr_data[4]); end
      ntests++; if (qr_resp[4] !== 1'b0) begin nfail++; $display("FAIL ahb_okay got %b want 0", qr_resp[4]); end
      @(posedge clk); #1;
      ntests++; if (hrdata_m !== 32'hFF77_BEEF) begin nfail++; $display("FAIL ahb_hold got %h want ff77beef", hrdata_m); end
   endtask

   task automatic test_arbiter;
      logic [31:0] rd;
      logic er;
      int n;
      sel = 1'b0;
      xreset = 1'b1;
      @(posedge clk); #1;
      xreset = 1'b0;
      qset(0, 1'b0, 10'h020, 3'd2, 32'h0);
      fork
         apb_xfer(1'b1, 10'h020, 4'hF, 32'h1234_5678, rd, er, n);
         ahb_run(1);
      join
      ntests++; if (n !== 2) begin nfail++; $display("FAIL tie1_apb_lat got %0d want 2", n); end
      ntests++; if (qr_low[0] !== 2) begin nfail++; $display("FAIL tie1_ahb_low got %0d want 2", qr_low[0]); end
      ntests++; if (qr_data[0] !== 32'h1234_5678) begin nfail++; $display("FAIL tie1_order got %h want 12345678", qr_data[0]); end
      apb_xfer(1'b0, 10'h020, 4'h0, 32'h0, rd, er, n);
      ntests++; if (rd !== 32'h1234_5678) begin nfail++; $display("FAIL tie_apb_rd got %h want 12345678", rd); end
      qset(0, 1'b1, 10'h024, 3'd2, 32'h0BAD_F00D);
      fork
         apb_xfer(1'b1, 10'h024, 4'hF, 32'h600D_CAFE, rd, er, n);
         ahb_run(1);
      join
      ntests++; if (qr_low[0] !== 1) begin nfail++; $display("FAIL tie2_ahb_low got %0d want 1", qr_low[0]); end
      ntests++; if (n !== 3) begin nfail++; $display("FAIL tie2_apb_lat got %0d want 3", n); end
      qset(0, 1'b0, 10'h024, 3'd2, 32'h0);
      ahb_run(1);
      ntests++; if (qr_data[0] !== 32'h600D_CAFE) begin nfail++; $display("FAIL tie2_order got %h want 600dcafe", qr_data[0]); end
   endtask

   task automatic test_errors;
      logic [31:0] rd;
      logic er;
      int n;
      sel = 1'b0;
      apb_xfer(1'b1, 10'h1FC, 4'hF, 32'h5A5A_1234, rd, er, n);
      ntests++; if (er !== 1'b0) begin nfail++; $display("FAIL top_word_err got %b want 0", er); end
      apb_xfer(1'b1, 10'h3FC, 4'hF, 32'hDEAD_BEEF, rd, er, n);
      ntests++; if (er !== 1'b1) begin nfail++; $display("FAIL apb_oor_err got %b want 1", er); end
      ntests++; if (n !== 2) begin nfail++; $display("FAIL apb_oor_lat got %0d want 2", n); end
      apb_xfer(1'b0, 10'h1FC, 4'h0, 32'h0, rd, er, n);
      ntests++; if (rd !== 32'h5A5A_1234) begin nfail++; $display("FAIL apb_oor_ram got %h want 5a5a1234", rd); end
      qset(0, 1'b0, 10'h200, 3'd2, 32'h0);
      qset(1, 1'b0, 10'h1FC, 3'd2, 32'h0);
      qset(2, 1'b0, 10'h004, 3'd3, 32'h0);
      ahb_run(3);
      ntests++; if (qr_low[0] !== 1) begin nfail++; $display("FAIL ahb_err1_low got %0d want 1", qr_low[0]); end
      ntests++; if (qr_resp1[0] !== 1'b1) begin nfail++; $display("FAIL ahb_err1_resp got %b want 1", qr_resp1[0]); end
      ntests++; if (qr_resp[0] !== 1'b1) begin nfail++; $display("FAIL ahb_err2_resp got %b want 1", qr_resp[0]); end
      ntests++; if (qr_data[1] !== 32'h5A5A_1234) begin nfail++; $display("FAIL ahb_after_err got %h want 5a5a1234", qr_data[1]); end
      ntests++; if (qr_resp[1] !== 1'b0) begin nfail++; $display("FAIL ahb_after_err_resp got %b want 0", qr_resp[1]); end
      ntests++; if (qr_resp1[2] !== 1'b1 || qr_resp[2] !== 1'b1) begin nfail++; $display("FAIL ahb_oversize got %b%b want 11", qr_resp1[2], qr_resp[2]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd;
      logic er;
      int n;
      sel = 1'b1;
      qset(0, 1'b1, 10'h3FC, 3'd2, 32'hCAFE_F00D);
      qset(1, 1'b1, 10'h000, 3'd2, 32'h1357_9BDF);
      qset(2, 1'b0, 10'h3FC, 3'd2, 32'h0);
      qset(3, 1'b0, 10'h000, 3'd2, 32'h0);
      ahb_run(4);
      for (int k = 0; k < 4; k++) begin
         ntests++; if (qr_low[k] !== 4) begin nfail++; $display("FAIL b2b_low[%0d] got %0d want 4", k, qr_low[k]); end
      end
      ntests++; if (qr_data[2] !== 32'hCAFE_F00D) begin nfail++; $display("FAIL b2b_rd0 got %h want cafef00d", qr_data[2]); end
      ntests++; if (qr_data[3] !== 32'h1357_9BDF) begin nfail++; $display("FAIL b2b_rd1 got %h want 13579bdf", qr_data[3]); end
      apb_xfer(1'b0, 10'h3FC, 4'h0, 32'h0, rd, er, n);
      ntests++; if (n !== 5) begin nfail++; $display("FAIL apb_wait_lat got %0d want 5", n); end
      ntests++; if (rd !== 32'hCAFE_F00D) begin nfail++; $display("FAIL apb_wait_rd got %h want cafef00d", rd); end
   endtask

   task automatic test_reset_in_wait;
      sel = 1'b1;
      hsel = 1'b1; htrans = 2'b10; haddr = 10'h3FC; hwrite = 1'b0; hsize = 3'd2;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(posedge clk); #1;
      ntests++; if (hreadyout_m !== 1'b0) begin nfail++; $display("FAIL wait_low got %b want 0", hreadyout_m); end
      #2;
      xreset = 1'b1;
      #1;
      ntests++; if (hreadyout_m !== 1'b1) begin nfail++; $display("FAIL async_rdy got %b want 1", hreadyout_m); end
      ntests++; if (hresp_m !== 1'b0) begin nfail++; $display("FAIL async_resp got %b want 0", hresp_m); end
      ntests++; if (hrdata_m !== 32'h0) begin nfail++; $display("FAIL async_hrdata got %h want 0", hrdata_m); end
      @(posedge clk); #1;
      xreset = 1'b0;
      @(posedge clk); #1;
      qset(0, 1'b0, 10'h3FC, 3'd2, 32'h0);
      qset(1, 1'b0, 10'h000, 3'd2, 32'h0);
      ahb_run(2);
      ntests++; if (qr_data[0] !== 32'hCAFE_F00D) begin nfail++; $display("FAIL keep0 got %h want cafef00d", qr_data[0]); end
      ntests++; if (qr_data[1] !== 32'h1357_9BDF) begin nfail++; $display("FAIL keep1 got %h want 13579bdf", qr_data[1]); end
      ntests++; if (qr_low[0] !== 4) begin nfail++; $display("FAIL keep_low got %0d want 4", qr_low[0]); end
   endtask

   initial begin
      xreset = 1'b1; sel = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pprot = 3'd0;
      paddr = '0; pstrb = '0; pwdata = '0;
      hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd0;
      haddr = '0; hwdata = '0; hprot = 4'd0; hburst = 3'd0; hmastlock = 1'b0;
      test_reset();
      test_apb_rw();
      test_ahb_lanes();
      test_arbiter();
      test_errors();
      test_back_to_back();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
